uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receives 8N1-style asynchronous serial frames on UART_RX and presents each
//  word on a valid/ready (AXI-stream style) output. It is the receive half of
//  the axis_uart IP, sitting between the board RX pin and the stream consumer.
//  Detects framing errors and reports output overrun.
// PARAMETERS
//  CLKRATE      100000000  clk frequency in Hz
//  BAUD         115200     line rate in bit/s; CLKRATE/BAUD must be >= 4
//  WORD_LENGTH  8          data bits per frame (LSB first, no parity, 1 stop)
// PORTS
//  clk            in   1            clock
//  rst            in   1            reset, synchronous, active-high
//  UART_RX        in   1            async serial input, idle high
//  rx_data        out  WORD_LENGTH  received word
//  rx_data_valid  out  1            rx_data holds an unconsumed word
//  rx_data_ready  in   1            consumer accepts word when valid&&ready
//  frame_error    out  1            1-cycle pulse: stop bit sampled low
//  overrun        out  1            1-cycle pulse: good frame dropped, buffer full
// BEHAVIOUR
//  - Reset values: rx_data=0, rx_data_valid=0, frame_error=0, overrun=0.
//    The 2-flop synchronizer presets to 1 and the FSM goes to IDLE. Reset
//    mid-frame abandons the frame without a valid, error or overrun pulse.
//  - BIT=CLKRATE/BAUD, HALF=BIT/2. Baud counter width is $clog2(BIT).
//    The counter clears on every state change. Bit counter width is
//    $clog2(WORD_LENGTH)+1.
//  - All decisions use rx_s, the output of the 2-flop synchronizer.
//  - FSM states:
//    IDLE: rx_s==0 -> START.
//    START: at count HALF-1, sample rx_s. If 0 -> DATA. If 1 -> IDLE
//      (glitch, no pulses).
//    DATA: at count BIT-1, sample rx_s and shift it into the shift register
//      MSB (LSB-first line order). After WORD_LENGTH samples -> STOP.
//    STOP: at count BIT-1, sample rx_s.
//      If 1 -> frame good, go to IDLE.
//      If 0 -> frame_error pulse, word discarded, go to BREAK.
//    BREAK: stay until rx_s==1, then IDLE. A held-low line gives only one
//      error.
//  - Sampling is therefore mid-bit: bit n is sampled HALF+BIT*(n+1) cycles
//    after the start edge is seen on rx_s.
//  - Output latency: rx_data/rx_data_valid update on the clock after the
//    good stop sample.
//  - Handshake: rx_data is stable while valid. valid clears the cycle after
//    valid&&ready. Valid does not depend combinationally on ready.
//  - Good frame while valid=1 and ready=0: overrun pulse, new word dropped,
//    old rx_data kept.
//  - Good frame in the same cycle as valid&&ready: new word loaded, valid
//    stays 1, no overrun.
//  - Back-to-back frames: IDLE detects the next start on the cycle after the
//    stop sample, with no idle gap required.
// TESTING (sim params CLKRATE=16, BAUD=1 -> BIT=16, HALF=8)
//  1. Frame 0xA5 with ready=1 -> rx_data=0xA5, valid high exactly 1 cycle,
//     no error or overrun.
//  2. Line low for 4 cycles then high -> back to IDLE, valid/error/overrun
//     all stay 0.
//  3. Frame 0x3C with stop bit 0, line held low 40 cycles -> exactly one
//     frame_error pulse, valid=0. After line high, frame 0x5A is received
//     OK.
//  4. ready=0, frames 0x11 then 0x22 -> rx_data=0x11, one overrun pulse at
//     the 2nd stop sample. Then ready=1 -> 0x11 consumed and valid drops.
//  5. Frames 0x01 and 0x7E with no gap, ready=1 -> two valid beats,
//     0x01 then 0x7E.
//  6. rst asserted mid-DATA of frame 0xFF -> no valid. Next frame 0x55 is
//     received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Asynchronous serial receiver (8N1 style) with a one-word
//               valid/ready output buffer, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKRATE     = 100000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   UART_RX,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_data_valid,
    input  logic                   rx_data_ready,
    output logic                   frame_error,
    output logic                   overrun
);

    localparam int c_bit    = CLKRATE / BAUD;
    localparam int c_half   = c_bit / 2;
    localparam int c_cnt_w  = $clog2(c_bit);
    localparam int c_bcnt_w = $clog2(WORD_LENGTH) + 1;

    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(c_bit - 1);
    localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(c_half - 1);
    localparam logic [c_bcnt_w-1:0] c_word_last = c_bcnt_w'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_sync_meta;
    logic                   r_rx_s;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_bcnt_w-1:0]    r_bit_cnt;
    logic [WORD_LENGTH-1:0] r_shift;
    logic                   w_bit_take;
    logic                   w_stop_good;
    logic                   w_stop_bad;

    // Two-flop synchronizer; presets high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
        end else begin
            r_sync_meta <= UART_RX;
            r_rx_s      <= r_sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bit_take   = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == c_half_last) begin
                    w_state_next = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_bit_take = 1'b1;
                    if (r_bit_cnt == c_word_last) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == c_bit_last) begin
                    if (r_rx_s) begin
                        w_stop_good  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Baud counter restarts on every state change and at each data-bit sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) || w_bit_take) begin
            r_cnt <= '0;
        end else if ((r_state == ST_START) || (r_state == ST_DATA) ||
                     (r_state == ST_STOP)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (w_state_next != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_take) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_bit_take) begin
                r_shift <= {r_rx_s, r_shift[WORD_LENGTH-1:1]};
            end
        end
    end

    // A new word may replace the held one only when that one leaves this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            frame_error   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_error <= w_stop_bad;
            overrun     <= 1'b0;
            if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
            if (w_stop_good) begin
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data       <= r_shift;
                    rx_data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (BIT=16, HALF=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       UART_RX;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       frame_error;
    logic       overrun;

    int n_total;
    int n_pass;
    int n_fail;

    int         mon_valid_cycles;
    int         mon_err_pulses;
    int         mon_ovr_pulses;
    logic [7:0] beats[$];

    int s_valid;
    int s_err;
    int s_ovr;
    int s_beats;

    uart_rx #(
        .CLKRATE    (16),
        .BAUD       (1),
        .WORD_LENGTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .UART_RX      (UART_RX),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes outputs mid-low-phase, well clear of both clock edges.
    initial begin
        mon_valid_cycles = 0;
        mon_err_pulses   = 0;
        mon_ovr_pulses   = 0;
    end
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (rx_data_valid) mon_valid_cycles++;
            if (frame_error)   mon_err_pulses++;
            if (overrun)       mon_ovr_pulses++;
            if (rx_data_valid && rx_data_ready) beats.push_back(rx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_valid = mon_valid_cycles;
        s_err   = mon_err_pulses;
        s_ovr   = mon_ovr_pulses;
        s_beats = beats.size();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d);
        UART_RX = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            idle(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_head(d);
        UART_RX = stop_bit;
        idle(16);
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        n_fail        = 0;
        rst           = 1'b1;
        UART_RX       = 1'b1;
        rx_data_ready = 1'b1;
        idle(3);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_valid", 32'(rx_data_valid), 32'h0);
        check("reset_frame_error", 32'(frame_error), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        idle(4);

        // 1: 0xA5, exact output timing around the stop sample
        snap();
        send_head(8'hA5);
        UART_RX = 1'b1;
        idle(10);
        check("t1_valid_before_stop", 32'(rx_data_valid), 32'h0);
        idle(1);
        check("t1_valid_at_stop", 32'(rx_data_valid), 32'h1);
        check("t1_rx_data", 32'(rx_data), 32'hA5);
        idle(1);
        check("t1_valid_cleared", 32'(rx_data_valid), 32'h0);
        idle(8);
        check("t1_valid_cycles", 32'(mon_valid_cycles - s_valid), 32'd1);
        check("t1_beats", 32'(beats.size() - s_beats), 32'd1);
        check("t1_beat_value", 32'(beats[s_beats]), 32'hA5);
        check("t1_no_error", 32'(mon_err_pulses - s_err), 32'd0);
        check("t1_no_overrun", 32'(mon_ovr_pulses - s_ovr), 32'd0);

        // 2: short low glitch is rejected
        snap();
        UART_RX = 1'b0;
        idle(4);
        UART_RX = 1'b1;
        idle(30);
        check("t2_no_valid", 32'(mon_valid_cycles - s_valid), 32'd0);
        check("t2_no_error", 32'(mon_err_pulses - s_err), 32'd0);
        check("t2_no_overrun", 32'(mon_ovr_pulses - s_ovr), 32'd0);

        // 3: bad stop bit with line held low gives one error, then recovery
        snap();
        send_frame(8'h3C, 1'b0);
        idle(40);
        UART_RX = 1'b1;
        idle(20);
        check("t3_one_error", 32'(mon_err_pulses - s_err), 32'd1);
        check("t3_no_valid", 32'(mon_valid_cycles - s_valid), 32'd0);
        snap();
        send_frame(8'h5A, 1'b1);
        idle(4);
        check("t3_recover_beats", 32'(beats.size() - s_beats), 32'd1);
        check("t3_recover_value", 32'(beats[s_beats]), 32'h5A);
        check("t3_recover_no_error", 32'(mon_err_pulses - s_err), 32'd0);

        // 4: overrun while the consumer stalls
        rx_data_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        idle(4);
        send_frame(8'h22, 1'b1);
        idle(4);
        check("t4_overrun", 32'(mon_ovr_pulses - s_ovr), 32'd1);
        check("t4_kept_data", 32'(rx_data), 32'h11);
        check("t4_still_valid", 32'(rx_data_valid), 32'h1);
        rx_data_ready = 1'b1;
        idle(2);
        check("t4_valid_dropped", 32'(rx_data_valid), 32'h0);
        check("t4_beats", 32'(beats.size() - s_beats), 32'd1);
        check("t4_beat_value", 32'(beats[s_beats]), 32'h11);

        // 5: back-to-back frames with no idle gap
        idle(4);
        snap();
        send_frame(8'h01, 1'b1);
        send_frame(8'h7E, 1'b1);
        idle(4);
        check("t5_beats", 32'(beats.size() - s_beats), 32'd2);
        check("t5_first", 32'(beats[s_beats]), 32'h01);
        check("t5_second", 32'(beats[s_beats+1]), 32'h7E);
        check("t5_no_overrun", 32'(mon_ovr_pulses - s_ovr), 32'd0);

        // 6: reset in the middle of a frame
        idle(4);
        snap();
        UART_RX = 1'b0;
        idle(16);
        for (int i = 0; i < 3; i++) begin
            UART_RX = 1'b1;
            idle(16);
        end
        rst = 1'b1;
        idle(2);
        check("t6_reset_rx_data", 32'(rx_data), 32'h0);
        check("t6_reset_valid", 32'(rx_data_valid), 32'h0);
        rst     = 1'b0;
        UART_RX = 1'b1;
        idle(100);
        check("t6_no_beat", 32'(beats.size() - s_beats), 32'd0);
        check("t6_no_error", 32'(mon_err_pulses - s_err), 32'd0);
        snap();
        send_frame(8'h55, 1'b1);
        idle(4);
        check("t6_next_beats", 32'(beats.size() - s_beats), 32'd1);
        check("t6_next_value", 32'(beats[s_beats]), 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
